// File: rtl/flip_pkg.sv
// flip_pkg: shared state encoding, default widths and saturating increment for the flip sequencer
package flip_pkg;

    typedef enum logic [1:0] {IDLE, RUN, ISSUE, DONE} state_t;

    localparam int N_DEF     = 8;
    localparam int CNT_W_DEF = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/flip_sequencer.sv
// flip_sequencer: feeds {accumulator, index} to the toggle unit and folds its result back
module flip_sequencer
    import flip_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [N-1:0]     i_init,
    input  logic [N-1:0]     i_idx,
    input  logic             i_idx_valid,
    input  logic             i_last,
    output logic             o_idx_ready,
    output logic [N-1:0]     o_a,
    output logic [N-1:0]     o_b,
    output logic             o_op_valid,
    input  logic [N-1:0]     i_res,
    input  logic             i_err,
    output logic             o_busy,
    output logic             o_done,
    output logic [N-1:0]     o_result,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t       state, state_nx;
    logic [N-1:0] acc;
    logic         last_flag;

    assign o_idx_ready = state == RUN;
    assign o_op_valid  = state == ISSUE;
    assign o_done      = state == DONE;
    assign o_busy      = state != IDLE;

    // next-state: one index per RUN/ISSUE pair, DONE after the op flagged last
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_start ? RUN : IDLE;
            RUN:     state_nx = i_idx_valid ? ISSUE : RUN;
            ISSUE:   state_nx = last_flag ? DONE : RUN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // datapath: operand capture on accept, result fold-back and final value at the closing ISSUE edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            acc       <= '0;
            last_flag <= 1'b0;
            o_a       <= '0;
            o_b       <= '0;
            o_result  <= '0;
            o_err_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    acc       <= i_init;
                    o_err_cnt <= '0;
                    last_flag <= 1'b0;
                end
                RUN: if (i_idx_valid) begin
                    o_a       <= acc;
                    o_b       <= i_idx;
                    last_flag <= i_last;
                end
                ISSUE: begin
                    if (i_err) o_err_cnt <= CNT_W'(sat_inc(32'(o_err_cnt), 32'(CNT_MAX)));
                    else       acc       <= i_res;
                    if (last_flag) o_result <= i_err ? acc : i_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flip_sequencer.sv
// tb_flip_sequencer: randomized and directed checks of the flip sequencer against a transaction model
module tb_flip_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] init = '0;
    logic [7:0] idx = '0;
    logic       idx_valid = 1'b0;
    logic       last = 1'b0;

    logic       idx_ready, op_valid, busy, done, err;
    logic [7:0] a, b, res, result, err_cnt;
    logic       idx_ready2, op_valid2, busy2, done2, err2;
    logic [7:0] a2, b2, res2, result2;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // toggle unit: flip bit b of a; indices outside 0..7 (including negative) flag an error
    assign err  = b[7:3] != 5'd0;
    assign res  = err ? a : a ^ (8'd1 << b[2:0]);
    assign err2 = b2[7:3] != 5'd0;
    assign res2 = err2 ? a2 : a2 ^ (8'd1 << b2[2:0]);

    flip_sequencer #(.N(8), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_init(init), .i_idx(idx),
        .i_idx_valid(idx_valid), .i_last(last), .o_idx_ready(idx_ready), .o_a(a), .o_b(b),
        .o_op_valid(op_valid), .i_res(res), .i_err(err), .o_busy(busy), .o_done(done),
        .o_result(result), .o_err_cnt(err_cnt)
    );

    flip_sequencer #(.N(8), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_init(init), .i_idx(idx),
        .i_idx_valid(idx_valid), .i_last(last), .o_idx_ready(idx_ready2), .o_a(a2), .o_b(b2),
        .o_op_valid(op_valid2), .i_res(res2), .i_err(err2), .o_busy(busy2), .o_done(done2),
        .o_result(result2), .o_err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // transaction model: busy span, one accept per RUN cycle, op the cycle after accept, done the cycle after the last op
    logic       mbusy = 1'b0, op_due = 1'b0, done_due = 1'b0;
    logic [7:0] macc = '0, mres = '0, cidx = '0;
    logic       clast = 1'b0;
    int         mcnt = 0, mcnt2 = 0, ops = 0, dones = 0;

    always @(negedge clk) begin
        logic exp_ready, n_op, n_done, was_busy;
        if (!rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_ready", idx_ready, 0);
            chk("rst_result", result, 0);
            chk("rst_cnt", err_cnt, 0);
            mbusy = 0; op_due = 0; done_due = 0;
            macc = 0; mres = 0; mcnt = 0; mcnt2 = 0;
        end else begin
            exp_ready = mbusy && !op_due && !done_due;
            was_busy  = mbusy;
            n_done    = 0;
            chk("busy", busy, mbusy);
            chk("ready", idx_ready, exp_ready);
            chk("op_valid", op_valid, op_due);
            chk("done", done, done_due);
            chk("result", result, mres);
            chk("err_cnt", err_cnt, mcnt);
            chk("err_cnt2", err_cnt2, mcnt2);
            chk("result2", result2, mres);
            chk("done2", done2, done_due);
            if (op_due) begin
                chk("o_a", a, macc);
                chk("o_b", b, cidx);
                ops++;
                if (cidx[7] || cidx >= 8) begin
                    if (mcnt < 255) mcnt++;
                    if (mcnt2 < 3) mcnt2++;
                end else begin
                    macc = macc ^ (8'd1 << cidx[2:0]);
                end
                if (clast) begin
                    n_done = 1;
                    mres = macc;
                end
            end
            n_op = exp_ready && idx_valid;
            if (n_op) begin
                cidx = idx;
                clast = last;
            end
            if (done_due) begin
                dones++;
                mbusy = 0;
            end
            if (!was_busy && start) begin
                mbusy = 1;
                macc = init;
                mcnt = 0;
                mcnt2 = 0;
            end
            op_due = n_op;
            done_due = n_done;
        end
    end

    task automatic do_start(input logic [7:0] v);
        start = 1; init = v;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [7:0] v, input logic l, input logic hold);
        logic ok;
        ok = 0;
        idx = v; last = l; idx_valid = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = idx_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (!hold) idx_valid = 0;
    endtask

    task automatic wait_done;
        logic ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        if (!ok) chk("done_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int ops0, dones0, len, r;
        logic [7:0] v;
        repeat (3) @(negedge clk);
        #1 rst = 1;
        @(posedge clk); #1;

        ops0 = ops; dones0 = dones;
        do_start(8'h00);
        send(8'd0, 0, 0); send(8'd3, 0, 0); send(8'd7, 1, 0);
        wait_done();
        chk("basic_result", result, 8'h89);
        chk("basic_cnt", err_cnt, 0);
        chk("basic_ops", ops - ops0, 3);
        chk("basic_dones", dones - dones0, 1);

        do_start(8'h0F);
        send(8'd8, 0, 0); send(8'd1, 1, 0);
        wait_done();
        chk("range_result", result, 8'h0D);
        chk("range_cnt", err_cnt, 1);

        do_start(8'hAA);
        send(8'h80, 1, 0);
        wait_done();
        chk("neg_result", result, 8'hAA);
        chk("neg_cnt", err_cnt, 1);

        do_start(8'h5C);
        send(8'd8, 0, 0); send(8'd9, 0, 0); send(8'h80, 0, 0); send(8'hFF, 0, 0); send(8'h20, 1, 0);
        wait_done();
        chk("sat_result", result2, 8'h5C);
        chk("sat_cnt2", err_cnt2, 3);
        chk("sat_cnt8", err_cnt, 5);

        ops0 = ops;
        do_start(8'h3C);
        send(8'd2, 0, 1); send(8'd2, 1, 0);
        wait_done();
        chk("hold_result", result, 8'h3C);
        chk("hold_ops", ops - ops0, 2);

        do_start(8'h10);
        do_start(8'h55);
        send(8'd1, 1, 0);
        wait_done();
        chk("busy_start_result", result, 8'h12);

        dones0 = dones;
        do_start(8'h33);
        send(8'd4, 0, 0);
        #2 rst = 0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_opv", op_valid, 0);
        chk("async_ready", idx_ready, 0);
        chk("async_done", done, 0);
        chk("async_a", a, 0);
        chk("async_b", b, 0);
        chk("async_result", result, 0);
        chk("async_cnt", err_cnt, 0);
        @(negedge clk); #1 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("async_no_done", dones - dones0, 0);
        do_start(8'h01);
        send(8'd0, 0, 0); send(8'd6, 1, 0);
        wait_done();
        chk("after_rst_result", result, 8'h40);

        for (int s = 0; s < 25; s++) begin
            do_start(8'($urandom));
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if ($urandom_range(0, 3) == 0) begin
                    start = 1; init = 8'($urandom);
                    @(posedge clk); #1;
                    start = 0;
                end
                r = $urandom_range(0, 3);
                v = (r < 3) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                send(v, k == len - 1, $urandom_range(0, 1) == 1 && k != len - 1);
            end
            wait_done();
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flip_sequencer.md
Name: flip_sequencer

Overview:
- Upstream/downstream control stage for the combinational bit-toggle unit; it feeds the toggle unit and consumes its output.
- Holds an N-bit accumulator and accepts a stream of bit indices over a valid/ready handshake.
- For each index it presents {accumulator, index} to the toggle unit, then captures the result (or the error flag) back into the accumulator.
- Reports the final value when the index marked last completes, plus a saturating error count.

Parameters:
N, 8, data and index width (index is signed-style: MSB set = negative = invalid)
CNT_W, 8, width of the saturating error counter

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-low
i_start  input  1  start pulse; loads i_init; honoured only in IDLE
i_init  input  N  initial accumulator value
i_idx  input  N  bit index to toggle
i_idx_valid  input  1  i_idx/i_last valid
i_last  input  1  qualifies i_idx as final index of the sequence
o_idx_ready  output  1  sequencer accepts an index this cycle
o_a  output  N  operand to toggle unit (accumulator snapshot)
o_b  output  N  index to toggle unit
o_op_valid  output  1  o_a/o_b valid for the toggle unit this cycle
i_res  input  N  toggle unit result
i_err  input  1  toggle unit error flag
o_busy  output  1  high in any state except IDLE
o_done  output  1  one-cycle pulse: sequence finished
o_result  output  N  final accumulator; valid when o_done, held until next start
o_err_cnt  output  CNT_W  saturating count of errored operations in current sequence

Behaviour:
- Reset (i_rst=0, async): state IDLE; accumulator, o_a, o_b, o_result, o_err_cnt = 0; o_idx_ready, o_op_valid, o_done, o_busy = 0. A reset mid-sequence abandons it; no o_done.
- FSM states: IDLE, RUN, ISSUE, DONE.
- IDLE:
  - i_start=1 -> acc=i_init, o_err_cnt=0, last_flag=0, go to RUN.
  - Other inputs are ignored.
- RUN:
  - o_idx_ready=1.
  - On i_idx_valid & o_idx_ready: o_a<=acc, o_b<=i_idx, last_flag<=i_last, go to ISSUE.
  - Without a valid, stay in RUN.
- ISSUE (exactly one cycle):
  - o_op_valid=1, o_idx_ready=0.
  - At the closing edge, sample i_res/i_err. The toggle unit is combinational, so the result is valid in the same cycle.
  - i_err=0 -> acc<=i_res.
  - i_err=1 -> acc unchanged; o_err_cnt<=o_err_cnt+1, saturating at 2^CNT_W-1.
  - last_flag=1 -> go to DONE, else go to RUN.
- DONE (one cycle):
  - o_done=1, o_result=acc (value including the final op), go to IDLE.
  - o_result and o_err_cnt hold until the next accepted i_start.
- Throughput and latency:
  - One index per 2 cycles.
  - Accept at edge t; operands visible cycle t..t+1; acc updated at edge t+1.
  - o_done asserted in the cycle after the last ISSUE.
- i_start outside IDLE: ignored.
- i_idx_valid with ready low: index is not consumed; the source must hold it. No double-consume across ISSUE.
- o_a/o_b hold their last values outside ISSUE; downstream qualifies them with o_op_valid only.
- No arithmetic on the index: range and sign checking belong to the toggle unit; this block trusts i_err.

Decomposition:
- Shared package flip_pkg holds:
  - FSM state enum (IDLE, RUN, ISSUE, DONE)
  - default N and CNT_W constants
  - a saturating-increment function
- Single module; no sub-module needed.
- The bench instantiates the existing toggle unit downstream (o_a/o_b -> inputs, outputs -> i_res/i_err).

Test Plan (N=8, real toggle unit connected):
- Basic sequence: start, init=0x00; indices 0, 3, 7 (7 with last) -> o_done once, o_result=0x89, o_err_cnt=0; o_op_valid exactly 3 single-cycle pulses.
- Range error: init=0x0F; indices 8, then 1 (last) -> first op errors (acc stays 0x0F); o_result=0x0D, o_err_cnt=1.
- Negative index: init=0xAA; index 0x80 (last) -> o_result=0xAA, o_err_cnt=1.
- Saturation (CNT_W=2): 5 invalid indices, last on 5th -> o_err_cnt=3.
- Handshake:
  - i_idx_valid held high continuously with indices 2, 2 (last): each accepted exactly once (ready low during ISSUE) -> o_result=init.
  - i_start pulsed while busy -> ignored.
- Reset mid-operation: drop i_rst asynchronously during ISSUE -> all outputs 0 immediately, no o_done. A new start then runs normally.
